// File: rtl/poseidon_input_assembler_if.sv
// Stream bundle for poseidon_input_assembler: beat input, assembled-state output and framing status.
// slave is the assembler side, master is the host/core side that drives beats and consumes states.
interface poseidon_input_assembler_if #(
    parameter int WIDTH = 255,
    parameter int ELEMS = 3
);
    logic                   io_input_valid;
    logic                   io_input_ready;
    logic                   io_input_last;
    logic [WIDTH-1:0]       io_input_payload;
    logic                   io_state_valid;
    logic                   io_state_ready;
    logic [WIDTH*ELEMS-1:0] io_state_payload;
    logic                   io_frame_err;
    logic [15:0]            io_err_count;
    logic [15:0]            io_pkt_count;

    modport slave (
        input  io_input_valid, io_input_last, io_input_payload, io_state_ready,
        output io_input_ready, io_state_valid, io_state_payload,
        output io_frame_err, io_err_count, io_pkt_count
    );

    modport master (
        output io_input_valid, io_input_last, io_input_payload, io_state_ready,
        input  io_input_ready, io_state_valid, io_state_payload,
        input  io_frame_err, io_err_count, io_pkt_count
    );
endinterface

// File: rtl/poseidon_input_assembler.sv
// Groups ELEMS field-element beats into one permutation state, checks framing, buffers states in a FWFT FIFO.
// Optional macro POSEIDON_ASM_PAD_SHORT_EN: short packets are zero-padded and pushed instead of flagged.
module poseidon_input_assembler #(
    parameter int WIDTH = 255,
    parameter int ELEMS = 3,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    poseidon_input_assembler_if.slave bus
);
    localparam int IDXW = $clog2(ELEMS);
    localparam int PW   = $clog2(DEPTH);
    localparam int SW   = WIDTH * ELEMS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ELEMS - 1);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DROP    = 1'b1;

    logic [0:0]       fsm;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] slots [ELEMS-1];
    logic [SW-1:0]    push_word;
    logic [SW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             frame_err;
    logic [15:0]      err_count;
    logic [15:0]      pkt_count;
    logic             accept;
    logic             at_last;
    logic             fifo_full;
    logic             collecting;
    logic             push;
    logic             pop;
    logic             short_err;
    logic             long_err;

    assign at_last    = (idx == LAST_IDX);
    assign fifo_full  = (count == (PW+1)'(DEPTH));
    assign collecting = (fsm == COLLECT);
    assign accept     = bus.io_input_valid && bus.io_input_ready;
    assign pop        = bus.io_state_valid && bus.io_state_ready;
    assign long_err   = accept && collecting && at_last && !bus.io_input_last;

`ifdef POSEIDON_ASM_PAD_SHORT_EN
    // Any final beat pushes a state here, so a short last beat must also wait for FIFO space.
    assign bus.io_input_ready = (fsm == DROP) || !fifo_full || (!at_last && !bus.io_input_last);
    assign push      = accept && collecting && bus.io_input_last;
    assign short_err = 1'b0;
`else
    assign bus.io_input_ready = (fsm == DROP) || !at_last || !fifo_full;
    assign push      = accept && collecting && at_last && bus.io_input_last;
    assign short_err = accept && collecting && !at_last && bus.io_input_last;
`endif

    // Elements above the current beat are left zero, which is the padding for short packets.
    always_comb begin
        push_word = '0;
        for (int k = 0; k < ELEMS; k++) begin
            if (IDXW'(k) == idx) begin
                push_word[k*WIDTH +: WIDTH] = bus.io_input_payload;
            end else if (IDXW'(k) < idx && k < ELEMS - 1) begin
                push_word[k*WIDTH +: WIDTH] = slots[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < ELEMS - 1; k++) begin
            if (accept && collecting && idx == IDXW'(k)) begin
                slots[k] <= bus.io_input_payload;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm <= COLLECT;
            idx <= '0;
        end else if (accept) begin
            if (fsm == DROP) begin
                if (bus.io_input_last) begin
                    fsm <= COLLECT;
                    idx <= '0;
                end
            end else if (bus.io_input_last || at_last) begin
                idx <= '0;
                if (at_last && !bus.io_input_last) begin
                    fsm <= DROP;
                end
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            err_count <= '0;
            pkt_count <= '0;
        end else begin
            frame_err <= short_err || long_err;
            if ((short_err || long_err) && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (push) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.io_state_valid   = (count != '0);
    assign bus.io_state_payload = mem[rd_ptr];
    assign bus.io_frame_err     = frame_err;
    assign bus.io_err_count     = err_count;
    assign bus.io_pkt_count     = pkt_count;
endmodule

// File: tb/tb_poseidon_input_assembler.sv
// Self-checking bench for poseidon_input_assembler: directed sequences, a framing vector table
// and randomized packets scored against a packet-level reference model.
module tb_poseidon_input_assembler;
    localparam int WIDTH   = 255;
    localparam int ELEMS   = 3;
    localparam int DEPTH   = 2;
    localparam int SW      = WIDTH * ELEMS;
    localparam int TIMEOUT = 200;

    typedef struct {
        int            len;
        int            first;
        bit            exp_err;
        bit            has_state;
        logic [SW-1:0] exp_state;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    poseidon_input_assembler_if #(.WIDTH(WIDTH), .ELEMS(ELEMS)) bus ();

    poseidon_input_assembler #(.WIDTH(WIDTH), .ELEMS(ELEMS), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int            assertions = 0;
    int            failures = 0;
    bit            rand_ready = 1'b0;
    logic [SW-1:0] got_q[$];
    logic [SW-1:0] exp_q[$];
    int            err_pulses = 0;
    int            stall_cycles = 0;

    // Observe handshakes on the falling edge, where inputs and registered outputs are settled.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.io_state_valid && bus.io_state_ready) got_q.push_back(bus.io_state_payload);
            if (bus.io_frame_err) err_pulses++;
            if (bus.io_input_valid && !bus.io_input_ready) stall_cycles++;
        end
    end

    task automatic checkOutput(input string name, input logic [SW-1:0] actual, input logic [SW-1:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [SW-1:0] pack3(input int e0, input int e1, input int e2);
        return {WIDTH'(e2), WIDTH'(e1), WIDTH'(e0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.io_state_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic doReset();
        bus.io_input_valid = 1'b0;
        bus.io_input_last = 1'b0;
        bus.io_input_payload = '0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit lst);
        int waited;
        waited = 0;
        bus.io_input_payload = d;
        bus.io_input_last = lst;
        bus.io_input_valid = 1'b1;
        @(negedge clk);
        while (!bus.io_input_ready && waited < TIMEOUT) begin
            tick();
            @(negedge clk);
            waited++;
        end
        if (!bus.io_input_ready) begin
            assertions++;
            failures++;
            $display("[TB] FAIL beat accept timeout: ready %0d required 1", bus.io_input_ready);
        end
        tick();
        bus.io_input_valid = 1'b0;
    endtask

    task automatic checkDelivered(input string name, input int base);
        checkOutput({name, " state count"}, SW'(got_q.size() - base), SW'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) checkOutput($sformatf("%s state %0d", name, i), got_q[base + i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        vec_t          tbl[7];
        int            base;
        int            e0;
        int            nerr;
        int            npush;
        int            len;
        int            err_at;
        logic [255:0]  r;
        logic [SW-1:0] word;

        bus.io_input_valid = 1'b0;
        bus.io_input_last = 1'b0;
        bus.io_input_payload = '0;
        bus.io_state_ready = 1'b0;
        doReset();

        checkOutput("reset state_valid", SW'(bus.io_state_valid), SW'(0));
        checkOutput("reset state_payload", bus.io_state_payload, SW'(0));
        checkOutput("reset frame_err", SW'(bus.io_frame_err), SW'(0));
        checkOutput("reset err_count", SW'(bus.io_err_count), SW'(0));
        checkOutput("reset pkt_count", SW'(bus.io_pkt_count), SW'(0));
        checkOutput("reset input_ready", SW'(bus.io_input_ready), SW'(1));

        // Single packet latency and layout
        bus.io_state_ready = 1'b1;
        base = got_q.size();
        applyStimulus(WIDTH'(1), 1'b0);
        applyStimulus(WIDTH'(2), 1'b0);
        checkOutput("t1 valid before last", SW'(bus.io_state_valid), SW'(0));
        applyStimulus(WIDTH'(3), 1'b1);
        checkOutput("t1 valid after last", SW'(bus.io_state_valid), SW'(1));
        checkOutput("t1 payload", bus.io_state_payload, pack3(1, 2, 3));
        checkOutput("t1 pkt_count", SW'(bus.io_pkt_count), SW'(1));
        checkOutput("t1 err_count", SW'(bus.io_err_count), SW'(0));
        tick();
        exp_q.push_back(pack3(1, 2, 3));
        checkDelivered("t1", base);

        // Sustained throughput
        doReset();
        base = got_q.size();
        e0 = stall_cycles;
        for (int p = 0; p < 100; p++) begin
            for (int b = 0; b < 3; b++) applyStimulus(WIDTH'(p*3 + b + 1), b == 2);
            exp_q.push_back(pack3(p*3 + 1, p*3 + 2, p*3 + 3));
        end
        idle(3);
        checkOutput("t2 stall cycles", SW'(stall_cycles - e0), SW'(0));
        checkOutput("t2 pkt_count", SW'(bus.io_pkt_count), SW'(100));
        checkDelivered("t2", base);

        // Back-pressure: full FIFO stalls the final beat of packet 3
        doReset();
        bus.io_state_ready = 1'b0;
        base = got_q.size();
        for (int v = 1; v <= 8; v++) applyStimulus(WIDTH'(v), v == 3 || v == 6);
        bus.io_input_payload = WIDTH'(9);
        bus.io_input_last = 1'b1;
        bus.io_input_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("t3 stalled ready", SW'(bus.io_input_ready), SW'(0));
            checkOutput("t3 held payload", bus.io_state_payload, pack3(1, 2, 3));
            tick();
        end
        bus.io_state_ready = 1'b1;
        applyStimulus(WIDTH'(9), 1'b1);
        idle(5);
        exp_q.push_back(pack3(1, 2, 3));
        exp_q.push_back(pack3(4, 5, 6));
        exp_q.push_back(pack3(7, 8, 9));
        checkDelivered("t3", base);

        // Framing vector table
`ifdef POSEIDON_ASM_PAD_SHORT_EN
        tbl[0] = '{2, 10, 1'b0, 1'b1, pack3(10, 11, 0)};
        tbl[2] = '{1, 20, 1'b0, 1'b1, pack3(20, 0, 0)};
`else
        tbl[0] = '{2, 10, 1'b1, 1'b0, SW'(0)};
        tbl[2] = '{1, 20, 1'b1, 1'b0, SW'(0)};
`endif
        tbl[1] = '{3, 4, 1'b0, 1'b1, pack3(4, 5, 6)};
        tbl[3] = '{5, 1, 1'b1, 1'b0, SW'(0)};
        tbl[4] = '{3, 7, 1'b0, 1'b1, pack3(7, 8, 9)};
        tbl[5] = '{4, 30, 1'b1, 1'b0, SW'(0)};
        tbl[6] = '{3, 40, 1'b0, 1'b1, pack3(40, 41, 42)};
        doReset();
        base = got_q.size();
        e0 = err_pulses;
        nerr = 0;
        npush = 0;
        for (int t = 0; t < 7; t++) begin
            err_at = (tbl[t].len < ELEMS) ? tbl[t].len - 1 : ELEMS - 1;
            for (int i = 0; i < tbl[t].len; i++) begin
                applyStimulus(WIDTH'(tbl[t].first + i), i == tbl[t].len - 1);
                checkOutput($sformatf("vec%0d beat%0d frame_err", t, i), SW'(bus.io_frame_err),
                            SW'(tbl[t].exp_err && i == err_at));
            end
            if (tbl[t].exp_err) nerr++;
            if (tbl[t].has_state) begin
                exp_q.push_back(tbl[t].exp_state);
                npush++;
            end
        end
        idle(3);
        checkOutput("vec err pulses", SW'(err_pulses - e0), SW'(nerr));
        checkOutput("vec err_count", SW'(bus.io_err_count), SW'(nerr));
        checkOutput("vec pkt_count", SW'(bus.io_pkt_count), SW'(npush));
        checkDelivered("vec", base);

        // Reset mid-packet with a buffered state
        doReset();
        bus.io_state_ready = 1'b0;
        for (int v = 1; v <= 4; v++) applyStimulus(WIDTH'(v), v == 3);
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("t6 async valid", SW'(bus.io_state_valid), SW'(0));
        checkOutput("t6 async pkt_count", SW'(bus.io_pkt_count), SW'(0));
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        checkOutput("t6 valid after release", SW'(bus.io_state_valid), SW'(0));
        checkOutput("t6 ready after release", SW'(bus.io_input_ready), SW'(1));
        bus.io_state_ready = 1'b1;
        base = got_q.size();
        for (int v = 11; v <= 13; v++) applyStimulus(WIDTH'(v), v == 13);
        idle(3);
        checkOutput("t6 pkt_count", SW'(bus.io_pkt_count), SW'(1));
        exp_q.push_back(pack3(11, 12, 13));
        checkDelivered("t6", base);

        // Randomized packets against the packet-level model
        doReset();
        rand_ready = 1'b1;
        base = got_q.size();
        e0 = err_pulses;
        nerr = 0;
        npush = 0;
        for (int p = 0; p < 60; p++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : ELEMS;
            word = '0;
            for (int i = 0; i < len; i++) begin
                r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                if (i < ELEMS) word[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
                idle($urandom_range(0, 2));
                applyStimulus(r[WIDTH-1:0], i == len - 1);
            end
            if (len == ELEMS) begin
                exp_q.push_back(word);
                npush++;
            end else if (len < ELEMS) begin
`ifdef POSEIDON_ASM_PAD_SHORT_EN
                exp_q.push_back(word);
                npush++;
`else
                nerr++;
`endif
            end else begin
                nerr++;
            end
        end
        rand_ready = 1'b0;
        bus.io_state_ready = 1'b1;
        idle(10);
        checkOutput("rand err pulses", SW'(err_pulses - e0), SW'(nerr));
        checkOutput("rand err_count", SW'(bus.io_err_count), SW'(nerr));
        checkOutput("rand pkt_count", SW'(bus.io_pkt_count), SW'(npush));
        checkDelivered("rand", base);

`ifndef POSEIDON_ASM_PAD_SHORT_EN
        // Error counter saturation with single-beat short packets
        doReset();
        bus.io_input_payload = '0;
        bus.io_input_last = 1'b1;
        bus.io_input_valid = 1'b1;
        repeat (65537) tick();
        bus.io_input_valid = 1'b0;
        bus.io_input_last = 1'b0;
        idle(2);
        checkOutput("sat err_count", SW'(bus.io_err_count), SW'(16'hFFFF));
        checkOutput("sat pkt_count", SW'(bus.io_pkt_count), SW'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/poseidon_input_assembler.md
Name: poseidon_input_assembler

Overview:
- Receiver for the Poseidon input stream: accepts 255-bit field-element beats on a valid/ready/last stream and groups every ELEMS beats into one permutation state.
- Checks packet framing and buffers complete states in a small FIFO.
- Presents each state as one wide word to the permutation core.
- Sits between the host/BFM-facing stream port and the permutation core inside PoseidonTopLevel.

Parameters:
WIDTH, 255, bits per field element / beat
ELEMS, 3, beats per packet (state width T)
DEPTH, 2, output FIFO entries, power of 2, >=2

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
io_input_valid  in  1  beat valid
io_input_ready  out  1  beat accepted when valid&&ready
io_input_last  in  1  marks final beat of packet
io_input_payload  in  WIDTH  field element
io_state_valid  out  1  assembled state available
io_state_ready  in  1  consumer accepts state
io_state_payload  out  WIDTH*ELEMS  element k at bits [k*WIDTH +: WIDTH], k=beat order
io_frame_err  out  1  one-cycle pulse per malformed packet
io_err_count  out  16  malformed packets, saturates at 16'hFFFF
io_pkt_count  out  16  states pushed to FIFO, wraps

Behaviour:
- Reset (async assert, sync release):
  - FSM=COLLECT, beat index idx=0, FIFO empty.
  - io_state_valid=0, io_state_payload=0, io_frame_err=0, both counters=0.
  - io_input_ready=1 immediately after release.
- FSM states COLLECT and DROP.
- COLLECT, beat accepted at idx<ELEMS-1, last=0: store into slot idx, idx++.
- COLLECT, beat accepted at idx<ELEMS-1, last=1: short packet. Discard slots, idx=0, io_frame_err=1 next cycle, err_count++.
- COLLECT, beat accepted at idx=ELEMS-1, last=1: push {beat, slots} to FIFO, idx=0, pkt_count++.
- COLLECT, beat accepted at idx=ELEMS-1, last=0: long packet. Discard, err pulse, err_count++, go to DROP.
- DROP: accept and discard every beat. On an accepted beat with last=1, go to COLLECT with idx=0. No further error for the same packet.
- io_input_ready = (FSM==DROP) || (idx<ELEMS-1) || (fifo_count<DEPTH).
  - Registered terms only; no combinational path from io_state_ready.
  - A pop in the same cycle does not free the stall.
- Output FIFO is first-word fall-through from a register.
  - Final beat accepted in cycle N gives io_state_valid=1 in N+1 (empty FIFO).
  - io_state_payload holds stable while valid && !ready.
  - Pop on valid && ready.
  - Push and pop in the same cycle: both happen, count unchanged, order preserved.
  - Full FIFO: push impossible, the final beat stalls.
- Throughput: 1 beat/cycle sustained while the consumer keeps io_state_ready=1.
- io_err_count holds at 16'hFFFF. io_pkt_count wraps 16'hFFFF->0.
- Reset mid-packet or mid-DROP: partial packet and FIFO contents are lost. The next beat after release is treated as beat 0.

Optional Feature:
- Macro POSEIDON_ASM_PAD_SHORT_EN.
- Defined: a short packet (last at idx<ELEMS-1) is not an error.
  - Unfilled elements are zero.
  - The state is pushed and pkt_count++, with no err pulse and no err_count change.
  - A short final beat with FIFO full stalls exactly like a normal final beat.
- Undefined: short packets are discarded and flagged as described in Behaviour.

Test Plan:
1. Reset, io_state_ready=1, beats 1,2,3 with last on 3rd -> io_state_valid one cycle after beat 3, payload {3,2,1}, pkt_count=1, err_count=0.
2. 100 back-to-back 3-beat packets, io_input_valid held 1, io_state_ready=1 -> io_input_ready never drops, 100 states in order, pkt_count=100.
3. io_state_ready=0, send 3 packets -> 2 buffered, io_input_ready=0 at idx=2 of packet 3; raise ready -> packet 3 accepted, all 3 delivered in order.
4. Beats A, B(last) then good packet 4,5,6 -> io_frame_err one-cycle pulse, err_count=1, only {6,5,4} output. With POSEIDON_ASM_PAD_SHORT_EN: {0,B,A} then {6,5,4}, err_count=0.
5. 5-beat packet with last on 5th, then 7,8,9 -> one err pulse, err_count=1, beats 4-5 consumed in DROP, only {9,8,7} output.
6. Assert resetn=0 after beat 1 of a packet and with one state in the FIFO -> after release io_state_valid=0, counters 0, next 3 beats form the first state.
